// File: rtl/arp_resolver.sv
// Next-hop MAC resolver: direct-mapped IP->MAC cache with ARP query, timeout and retry.
// Optional ARP_RESOLVER_BCAST_EN answers limited/subnet broadcast requests with the broadcast MAC.
module arp_resolver #(
    parameter int CACHE_ADDR_WIDTH = 3,
    parameter int RETRY_COUNT      = 2,
    parameter int TIMEOUT_CYCLES   = 15625
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        query_valid,
    input  logic        query_ready,
    output logic [31:0] query_ip,
    input  logic        fill_valid,
    input  logic [31:0] fill_ip,
    input  logic [47:0] fill_mac,
    input  logic        clear_cache,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,
    output logic        busy
);
    localparam int ENTRIES = 1 << CACHE_ADDR_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, QUERY, WAIT_FILL, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [31:0]   next_hop_q, next_hop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [47:0]   resp_mac_q, resp_mac_d;
    logic          resp_err_q, resp_err_d;
    logic          req_ready_q, resp_valid_q, query_valid_q, busy_q;
    logic [31:0]   query_ip_q;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [31:0]        tag_mem [ENTRIES];
    logic [47:0]        mac_mem [ENTRIES];

    logic [CACHE_ADDR_WIDTH-1:0] fill_idx, lookup_idx;
    logic cache_we, fill_match, hit, req_bcast;

    assign fill_idx   = fill_ip[CACHE_ADDR_WIDTH-1:0];
    assign lookup_idx = next_hop_q[CACHE_ADDR_WIDTH-1:0];
    assign cache_we   = fill_valid && !clear_cache;
    assign fill_match = fill_valid && (fill_ip == next_hop_q);
    assign hit        = valid_q[lookup_idx] && (tag_mem[lookup_idx] == next_hop_q);

`ifdef ARP_RESOLVER_BCAST_EN
    assign req_bcast = (arp_request_ip == 32'hFFFF_FFFF) ||
                       (arp_request_ip == (local_ip | ~subnet_mask));
`else
    assign req_bcast = 1'b0;
`endif

    // Clear takes priority over a coincident fill.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
        always_comb begin
            valid_d[gi] = valid_q[gi];
            if (clear_cache)
                valid_d[gi] = 1'b0;
            else if (fill_valid && (fill_idx == CACHE_ADDR_WIDTH'(gi)))
                valid_d[gi] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cache_we) begin
            tag_mem[fill_idx] <= fill_ip;
            mac_mem[fill_idx] <= fill_mac;
        end
    end

    always_comb begin
        state_d    = state_q;
        next_hop_d = next_hop_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        resp_mac_d = resp_mac_q;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: begin
                if (arp_request_valid && req_ready_q) begin
                    if (arp_request_ip == 32'd0) begin
                        state_d    = RESPOND;
                        resp_err_d = 1'b1;
                        resp_mac_d = '0;
                    end else if (req_bcast) begin
                        state_d    = RESPOND;
                        resp_err_d = 1'b0;
                        resp_mac_d = '1;
                    end else begin
                        next_hop_d = ((arp_request_ip & subnet_mask) == (local_ip & subnet_mask))
                                     ? arp_request_ip : gateway_ip;
                        state_d    = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (fill_match) begin
                    state_d    = RESPOND;
                    resp_err_d = 1'b0;
                    resp_mac_d = fill_mac;
                end else if (hit) begin
                    state_d    = RESPOND;
                    resp_err_d = 1'b0;
                    resp_mac_d = mac_mem[lookup_idx];
                end else begin
                    state_d = QUERY;
                    retry_d = RW'(RETRY_COUNT);
                end
            end
            QUERY: begin
                if (query_ready) begin
                    state_d = WAIT_FILL;
                    timer_d = TW'(TIMEOUT_CYCLES);
                end
            end
            WAIT_FILL: begin
                if (fill_match) begin
                    state_d    = RESPOND;
                    resp_err_d = 1'b0;
                    resp_mac_d = fill_mac;
                end else if (timer_q == '0) begin
                    if (retry_q != '0) begin
                        retry_d = retry_q - 1'b1;
                        state_d = QUERY;
                    end else begin
                        state_d    = RESPOND;
                        resp_err_d = 1'b1;
                        resp_mac_d = '0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            RESPOND: begin
                if (arp_response_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            next_hop_q    <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            resp_mac_q    <= '0;
            resp_err_q    <= 1'b0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            query_valid_q <= 1'b0;
            query_ip_q    <= '0;
            busy_q        <= 1'b0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            next_hop_q    <= next_hop_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            resp_mac_q    <= resp_mac_d;
            resp_err_q    <= resp_err_d;
            req_ready_q   <= (state_d == IDLE);
            resp_valid_q  <= (state_d == RESPOND);
            query_valid_q <= (state_d == QUERY);
            query_ip_q    <= next_hop_d;
            busy_q        <= (state_d != IDLE);
            valid_q       <= valid_d;
        end
    end

    assign arp_request_ready  = req_ready_q;
    assign arp_response_valid = resp_valid_q;
    assign arp_response_error = resp_err_q;
    assign arp_response_mac   = resp_mac_q;
    assign query_valid        = query_valid_q;
    assign query_ip           = query_ip_q;
    assign busy               = busy_q;
endmodule
